icache_l1_l2_arb_itf: RTL and testbench

ICACHE_L1_L2_ARB_ITF -- requirements
Module: icache_l1_l2_arb_itf

---
 rtl/icache_l1_l2_arb_itf.sv | 235 +++++++++++++++++++++++
 tb/tb_icache_l1_l2_arb_itf.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_l1_l2_arb_itf.sv
// Refill arbiter between NUM_CH private instruction caches and one L2 fetch port, with boot/sleep handshake.
// Optional performance counters are built when ICACHE_ITF_PERF_CNT_EN is defined.
module icache_l1_l2_arb_itf #(
   parameter int NUM_CH = 4,
   parameter int ADDR_W = 19,
   parameter int LEN_W  = 4,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     c_cfg_itf_single_fetch,
   input  logic                     c_cfg_itf_irq_en,
   input  logic                     core_sleep_irq_pulse,
   input  logic [NUM_CH-1:0]        pri_cache_refill_req,
   input  logic [NUM_CH*ADDR_W-1:0] pri_cache_refill_addr,
   input  logic [NUM_CH*LEN_W-1:0]  pri_cache_refill_lenth,
   output logic [NUM_CH-1:0]        pri_cache_refill_gnt,
   output logic [NUM_CH-1:0]        pri_cache_refill_r_valid,
   output logic [31:0]              pri_cache_refill_r_data,
   output logic [NUM_CH-1:0]        pri_cache_refill_done,
   output logic                     icache_work_en,
   output logic                     icache_lowpower_en,
   output logic [31:0]              boot_addr_i,
   output logic                     fetch_L2cache_req,
   output logic [31:0]              fetch_L2cache_info,
   input  logic                     fetch_L2cache_gnt,
   input  logic [31:0]              fetch_L2cache_r_data,
   input  logic                     fetch_L2cache_r_valid,
   output logic                     fetch_L2cache_r_ready
`ifdef ICACHE_ITF_PERF_CNT_EN
   ,
   output logic [31:0]              perf_miss_cnt,
   output logic [31:0]              perf_beat_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_SLEEP = 2'd0,
      ST_IDLE  = 2'd1,
      ST_MISS  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   boot_q, boot_d;
   logic                work_en_q, work_en_d;
   logic                sleep_pend_q, sleep_pend_d;
   logic [CH_W-1:0]     rr_q, rr_d;
   logic [LEN_W:0]      beat_q, beat_d;
   logic [CH_W-1:0]     ch_q, ch_d;

   logic                sleep_set_s;
   logic                sleep_act_s;
   logic                arb_hit_s;
   logic [CH_W-1:0]     arb_sel_s;
   logic [ADDR_W-1:0]   sel_addr_s;
   logic [LEN_W-1:0]    sel_len_s;
   logic                l2_req_s;
   logic [31:0]         l2_info_s;
   logic [NUM_CH-1:0]   gnt_s;
   logic [NUM_CH-1:0]   rvalid_s;
   logic [NUM_CH-1:0]   done_s;
   logic                miss_evt_s;
   logic                beat_evt_s;

   function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int off);
      int t;
      t = int'(base) + off;
      if (t >= NUM_CH) begin
         t = t - NUM_CH;
      end else begin
         t = t;
      end
      return CH_W'(t);
   endfunction

   // A sleep pulse in the current cycle already counts as pending so it wins over refills.
   assign sleep_set_s = core_sleep_irq_pulse & c_cfg_itf_irq_en;
   assign sleep_act_s = sleep_pend_q | sleep_set_s;

   // Round-robin scan starting at the channel after the last grant.
   always_comb begin
      arb_hit_s = 1'b0;
      arb_sel_s = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!arb_hit_s && pri_cache_refill_req[rr_idx(rr_q, i)]) begin
            arb_hit_s = 1'b1;
            arb_sel_s = rr_idx(rr_q, i);
         end else begin
            arb_sel_s = arb_sel_s;
         end
      end
   end

   assign sel_addr_s = pri_cache_refill_addr[arb_sel_s*ADDR_W +: ADDR_W];
   assign sel_len_s  = pri_cache_refill_lenth[arb_sel_s*LEN_W +: LEN_W];

   // Next-state and output decode of the SLEEP/IDLE/MISS controller.
   always_comb begin
      state_d      = state_q;
      boot_d       = boot_q;
      work_en_d    = work_en_q;
      sleep_pend_d = sleep_pend_q | sleep_set_s;
      rr_d         = rr_q;
      beat_d       = beat_q;
      ch_d         = ch_q;
      l2_req_s     = 1'b0;
      l2_info_s    = 32'h0000_0000;
      gnt_s        = '0;
      rvalid_s     = '0;
      done_s       = '0;
      miss_evt_s   = 1'b0;
      beat_evt_s   = 1'b0;
      case (state_q)
         ST_SLEEP: begin
            if (fetch_L2cache_r_valid) begin
               boot_d    = fetch_L2cache_r_data[ADDR_W-1:0];
               work_en_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               state_d   = ST_SLEEP;
            end
         end
         ST_IDLE: begin
            if (sleep_act_s) begin
               l2_req_s  = 1'b1;
               l2_info_s = 32'h8000_0000;
               if (fetch_L2cache_gnt) begin
                  state_d      = ST_SLEEP;
                  work_en_d    = 1'b0;
                  sleep_pend_d = 1'b0;
               end else begin
                  state_d      = ST_IDLE;
               end
            end else if (arb_hit_s) begin
               l2_req_s  = 1'b1;
               l2_info_s[ADDR_W-1:0]              = sel_addr_s;
               l2_info_s[ADDR_W +: LEN_W]         = sel_len_s;
               l2_info_s[ADDR_W+LEN_W]            = c_cfg_itf_single_fetch;
               l2_info_s[ADDR_W+LEN_W+1 +: CH_W]  = arb_sel_s;
               gnt_s[arb_sel_s] = fetch_L2cache_gnt;
               if (fetch_L2cache_gnt) begin
                  ch_d       = arb_sel_s;
                  beat_d     = c_cfg_itf_single_fetch ? {{LEN_W{1'b0}}, 1'b1}
                                                      : ({1'b0, sel_len_s} + {{LEN_W{1'b0}}, 1'b1});
                  rr_d       = rr_idx(arb_sel_s, 1);
                  state_d    = ST_MISS;
                  miss_evt_s = 1'b1;
               end else begin
                  state_d    = ST_IDLE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MISS: begin
            if (fetch_L2cache_r_valid) begin
               rvalid_s[ch_q] = 1'b1;
               beat_evt_s     = 1'b1;
               beat_d         = beat_q - {{LEN_W{1'b0}}, 1'b1};
               if (beat_q == {{LEN_W{1'b0}}, 1'b1}) begin
                  done_s[ch_q] = 1'b1;
                  state_d      = ST_IDLE;
               end else begin
                  state_d      = ST_MISS;
               end
            end else begin
               state_d = ST_MISS;
            end
         end
         default: begin
            state_d = ST_SLEEP;
         end
      endcase
   end

   // Controller state, boot address, RR pointer and refill tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_SLEEP;
         boot_q       <= '0;
         work_en_q    <= 1'b0;
         sleep_pend_q <= 1'b0;
         rr_q         <= '0;
         beat_q       <= '0;
         ch_q         <= '0;
      end else begin
         state_q      <= state_d;
         boot_q       <= boot_d;
         work_en_q    <= work_en_d;
         sleep_pend_q <= sleep_pend_d;
         rr_q         <= rr_d;
         beat_q       <= beat_d;
         ch_q         <= ch_d;
      end
   end

   assign pri_cache_refill_gnt     = gnt_s;
   assign pri_cache_refill_r_valid = rvalid_s;
   assign pri_cache_refill_done    = done_s;
   assign pri_cache_refill_r_data  = fetch_L2cache_r_data;
   assign icache_work_en           = work_en_q;
   assign icache_lowpower_en       = sleep_set_s;
   assign boot_addr_i              = 32'(boot_q);
   assign fetch_L2cache_req        = l2_req_s;
   assign fetch_L2cache_info       = l2_info_s;
   assign fetch_L2cache_r_ready    = 1'b1;

`ifdef ICACHE_ITF_PERF_CNT_EN
   logic [31:0] miss_cnt_q;
   logic [31:0] beat_cnt_q;

   // Saturating grant and routed-beat counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         miss_cnt_q <= 32'h0000_0000;
         beat_cnt_q <= 32'h0000_0000;
      end else begin
         if (miss_evt_s && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
         end else begin
            miss_cnt_q <= miss_cnt_q;
         end
         if (beat_evt_s && (beat_cnt_q != 32'hFFFF_FFFF)) begin
            beat_cnt_q <= beat_cnt_q + 32'd1;
         end else begin
            beat_cnt_q <= beat_cnt_q;
         end
      end
   end

   assign perf_miss_cnt = miss_cnt_q;
   assign perf_beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_icache_l1_l2_arb_itf.sv
// Directed + randomized bench for icache_l1_l2_arb_itf; expectations come from a transaction-level model.
module tb_icache_l1_l2_arb_itf;

   localparam int NCH = 4;
   localparam int AW  = 19;
   localparam int LW  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              single_fetch = 1'b0;
   logic              irq_en = 1'b0;
   logic              sleep_pulse = 1'b0;
   logic [NCH-1:0]    req = '0;
   logic [NCH*AW-1:0] addr_v = '0;
   logic [NCH*LW-1:0] len_v = '0;
   logic [NCH-1:0]    gnt_o;
   logic [NCH-1:0]    rvalid_o;
   logic [31:0]       rdata_o;
   logic [NCH-1:0]    done_o;
   logic              work_en;
   logic              lowpower;
   logic [31:0]       boot_addr;
   logic              l2_req;
   logic [31:0]       l2_info;
   logic              l2_gnt = 1'b0;
   logic [31:0]       l2_rdata = 32'h0;
   logic              l2_rvalid = 1'b0;
   logic              l2_rready;
`ifdef ICACHE_ITF_PERF_CNT_EN
   logic [31:0]       perf_miss;
   logic [31:0]       perf_beat;
`endif

   int total = 0;
   int bad   = 0;
   int last_gnt;
   int m_miss;
   int m_beat;

   always #5 clk = ~clk;

   icache_l1_l2_arb_itf dut (
      .clk                      (clk),
      .rst                      (rst),
      .c_cfg_itf_single_fetch   (single_fetch),
      .c_cfg_itf_irq_en         (irq_en),
      .core_sleep_irq_pulse     (sleep_pulse),
      .pri_cache_refill_req     (req),
      .pri_cache_refill_addr    (addr_v),
      .pri_cache_refill_lenth   (len_v),
      .pri_cache_refill_gnt     (gnt_o),
      .pri_cache_refill_r_valid (rvalid_o),
      .pri_cache_refill_r_data  (rdata_o),
      .pri_cache_refill_done    (done_o),
      .icache_work_en           (work_en),
      .icache_lowpower_en       (lowpower),
      .boot_addr_i              (boot_addr),
      .fetch_L2cache_req        (l2_req),
      .fetch_L2cache_info       (l2_info),
      .fetch_L2cache_gnt        (l2_gnt),
      .fetch_L2cache_r_data     (l2_rdata),
      .fetch_L2cache_r_valid    (l2_rvalid),
      .fetch_L2cache_r_ready    (l2_rready)
`ifdef ICACHE_ITF_PERF_CNT_EN
      ,
      .perf_miss_cnt            (perf_miss),
      .perf_beat_cnt            (perf_beat)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // Next channel: first requester strictly after the last granted channel, wrapping.
   function automatic int rr_pick(input logic [NCH-1:0] mask, input int last);
      for (int k = 1; k <= NCH; k++) begin
         if (mask[(last + k) % NCH]) return (last + k) % NCH;
      end
      return 0;
   endfunction

   function automatic logic [31:0] exp_info(input int ch, input logic [AW-1:0] a,
                                            input logic [LW-1:0] l, input logic s);
      logic [31:0] v;
      v = 32'(a);
      v = v | (32'(l) << AW);
      v = v | (32'(s) << (AW + LW));
      v = v | (32'(ch) << (AW + LW + 1));
      return v;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req = '0; l2_gnt = 1'b0; l2_rvalid = 1'b0; sleep_pulse = 1'b0;
      #1;
      chk("rst_work_en", 32'(work_en), 32'd0);
      chk("rst_boot_addr", boot_addr, 32'd0);
      chk("rst_l2_req", 32'(l2_req), 32'd0);
      chk("rst_gnt", 32'(gnt_o), 32'd0);
      chk("rst_rvalid", 32'(rvalid_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_rready", 32'(l2_rready), 32'd1);
`ifdef ICACHE_ITF_PERF_CNT_EN
      chk("rst_perf_miss", perf_miss, 32'd0);
      chk("rst_perf_beat", perf_beat, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      last_gnt = NCH - 1;
      m_miss = 0;
      m_beat = 0;
   endtask

   task automatic do_boot(input logic [31:0] d);
      logic [AW-1:0] low;
      low = d[AW-1:0];
      @(negedge clk);
      l2_rvalid = 1'b1; l2_rdata = d;
      #1;
      chk("boot_pre_work_en", 32'(work_en), 32'd0);
      chk("boot_no_chan_valid", 32'(rvalid_o), 32'd0);
      @(negedge clk);
      l2_rvalid = 1'b0;
      #1;
      chk("boot_addr", boot_addr, 32'(low));
      chk("boot_work_en", 32'(work_en), 32'd1);
   endtask

   task automatic do_refill(input logic [NCH-1:0] mask, input logic [NCH*AW-1:0] av,
                            input logic [NCH*LW-1:0] lv, input logic s, input int sleep_beat,
                            output int ch, output bit slept);
      int wait_n, nb, b;
      logic [AW-1:0] ad;
      logic [LW-1:0] ln;
      @(negedge clk);
      req = mask; addr_v = av; len_v = lv; single_fetch = s; l2_gnt = 1'b0;
      ch = rr_pick(mask, last_gnt);
      ad = av[ch*AW +: AW];
      ln = lv[ch*LW +: LW];
      wait_n = $urandom_range(0, 1);
      for (int w = 0; w < wait_n; w++) begin
         #1;
         chk("wait_l2_req", 32'(l2_req), 32'd1);
         chk("wait_info", l2_info, exp_info(ch, ad, ln, s));
         chk("wait_gnt_vec", 32'(gnt_o), 32'd0);
         @(negedge clk);
      end
      l2_gnt = 1'b1;
      #1;
      chk("refill_l2_req", 32'(l2_req), 32'd1);
      chk("refill_info", l2_info, exp_info(ch, ad, ln, s));
      chk("refill_gnt_vec", 32'(gnt_o), 32'd1 << ch);
      nb = s ? 1 : int'(ln) + 1;
      b = 0;
      slept = 1'b0;
      @(negedge clk);
      l2_gnt = 1'b0; req = '0;
      while (b < nb) begin
         l2_rvalid   = ($urandom_range(0, 2) != 0);
         l2_rdata    = $urandom;
         sleep_pulse = l2_rvalid && (b + 1 == sleep_beat);
         #1;
         chk("miss_no_l2_req", 32'(l2_req), 32'd0);
         chk("lowpower", 32'(lowpower), 32'(sleep_pulse & irq_en));
         chk("rdata_mirror", rdata_o, l2_rdata);
         if (l2_rvalid) begin
            b++;
            m_beat++;
            chk("beat_valid", 32'(rvalid_o), 32'd1 << ch);
            chk("beat_done", 32'(done_o), (b == nb) ? (32'd1 << ch) : 32'd0);
         end else begin
            chk("gap_valid", 32'(rvalid_o), 32'd0);
            chk("gap_done", 32'(done_o), 32'd0);
         end
         if (sleep_pulse && irq_en) slept = 1'b1;
         @(negedge clk);
      end
      l2_rvalid = 1'b0; sleep_pulse = 1'b0;
      last_gnt = ch;
      m_miss++;
   endtask

   task automatic do_sleep(input logic [NCH-1:0] bystanders, input logic with_pulse);
      @(negedge clk);
      req = bystanders; sleep_pulse = with_pulse; l2_gnt = 1'b0;
      #1;
      chk("sleep_req", 32'(l2_req), 32'd1);
      chk("sleep_info", l2_info, 32'h8000_0000);
      chk("sleep_no_gnt", 32'(gnt_o), 32'd0);
      chk("sleep_lowpower", 32'(lowpower), 32'(with_pulse & irq_en));
      @(negedge clk);
      sleep_pulse = 1'b0; l2_gnt = 1'b1;
      #1;
      chk("sleep_gnt_info", l2_info, 32'h8000_0000);
      chk("sleep_gnt_no_chan", 32'(gnt_o), 32'd0);
      @(negedge clk);
      l2_gnt = 1'b0;
      #1;
      chk("slept_work_en", 32'(work_en), 32'd0);
      chk("slept_ignores_req", 32'(l2_req), 32'd0);
      chk("slept_no_gnt", 32'(gnt_o), 32'd0);
      req = '0;
   endtask

   task automatic rand_vecs(output logic [NCH*AW-1:0] av, output logic [NCH*LW-1:0] lv);
      for (int i = 0; i < NCH; i++) begin
         av[i*AW +: AW] = AW'($urandom);
         lv[i*LW +: LW] = LW'($urandom);
      end
   endtask

   initial begin
      logic [NCH*AW-1:0] av;
      logic [NCH*LW-1:0] lv;
      logic [NCH-1:0]    mask;
      int                ch;
      bit                slept;
      int                sb;

      do_reset();
      do_boot(32'h0001_2345);

      // Stray read data in IDLE goes nowhere.
      @(negedge clk);
      l2_rvalid = 1'b1; l2_rdata = 32'hDEAD_BEEF;
      #1;
      chk("idle_drop_valid", 32'(rvalid_o), 32'd0);
      chk("idle_drop_done", 32'(done_o), 32'd0);
      chk("idle_no_req", 32'(l2_req), 32'd0);
      @(negedge clk);
      l2_rvalid = 1'b0;

      // Single 4-beat refill on channel 2.
      rand_vecs(av, lv);
      av[2*AW +: AW] = 19'h00100;
      lv[2*LW +: LW] = 4'd3;
      do_refill(4'b0100, av, lv, 1'b0, 0, ch, slept);
      chk("single_refill_ch", 32'(ch), 32'd2);

      // Round-robin between channels 0 and 3.
      do_reset();
      do_boot($urandom);
      for (int i = 0; i < 4; i++) begin
         rand_vecs(av, lv);
         do_refill(4'b1001, av, lv, 1'b1, 0, ch, slept);
         chk("rr_order", 32'(ch), (i % 2 == 0) ? 32'd0 : 32'd3);
      end

      // Sleep pulse beats a simultaneous refill request.
      irq_en = 1'b1;
      do_sleep(4'b0010, 1'b1);
      irq_en = 1'b0;
      do_boot($urandom);

      // Sleep pulse during a refill is deferred until the refill completes.
      irq_en = 1'b1;
      rand_vecs(av, lv);
      lv = {NCH{4'd3}};
      do_refill(4'b0001, av, lv, 1'b0, 2, ch, slept);
      #1;
      chk("deferred_sleep_req", 32'(l2_req), 32'd1);
      chk("deferred_sleep_info", l2_info, 32'h8000_0000);
      do_sleep(4'b0000, 1'b0);
      irq_en = 1'b0;
      do_boot($urandom);

      // Reset in the middle of a refill.
      @(negedge clk);
      req = 4'b0010; len_v = {NCH{4'd3}}; single_fetch = 1'b0; l2_gnt = 1'b1;
      #1;
      chk("midrst_gnt", 32'(gnt_o), 32'b0010);
      @(negedge clk);
      l2_gnt = 1'b0; req = '0; l2_rvalid = 1'b1;
      #1;
      chk("midrst_beat1", 32'(rvalid_o), 32'b0010);
      chk("midrst_beat1_done", 32'(done_o), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_no_done", 32'(done_o), 32'd0);
      chk("midrst_no_valid", 32'(rvalid_o), 32'd0);
      chk("midrst_work_en", 32'(work_en), 32'd0);
`ifdef ICACHE_ITF_PERF_CNT_EN
      chk("midrst_perf_miss", perf_miss, 32'd0);
      chk("midrst_perf_beat", perf_beat, 32'd0);
`endif
      do_reset();
      do_boot($urandom);

      // Randomized traffic.
      for (int it = 0; it < 40; it++) begin
         mask   = NCH'($urandom_range(1, (1 << NCH) - 1));
         irq_en = 1'($urandom_range(0, 1));
         sb     = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
         rand_vecs(av, lv);
         do_refill(mask, av, lv, 1'($urandom_range(0, 1)), sb, ch, slept);
         if (slept) begin
            #1;
            chk("rand_sleep_first_idle", 32'(l2_req), 32'd1);
            do_sleep(mask, 1'b0);
            do_boot($urandom);
         end
      end
      irq_en = 1'b0;

`ifdef ICACHE_ITF_PERF_CNT_EN
      #1;
      chk("perf_miss", perf_miss, 32'(m_miss));
      chk("perf_beat", perf_beat, 32'(m_beat));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
